// File: rtl/csa_accumulator.sv
// csa_accumulator: folds a packet of carry-save (sum, carry) beats into a
// registered carry-save accumulator using a 4:2 reduction per beat. On the
// last beat a single carry-propagate add resolves the accumulator, and the
// binary result is offered on a valid/ready output.
module csa_accumulator #(
    parameter int WIDTH_I   = 8,
    parameter int MAX_TERMS = 16,
    parameter int WIDTH_O   = WIDTH_I + 1 + $clog2(MAX_TERMS),
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH_I-1:0] cs_sum_i,
    input  logic [WIDTH_I-1:0] cs_carry_i,
    input  logic               in_last_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH_O-1:0] result_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               overflow_o
);

    localparam logic [1:0] ST_ACCUM   = 2'd0;
    localparam logic [1:0] ST_RESOLVE = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    logic [1:0]         state_q,     state_d;
    logic [WIDTH_O-1:0] acc_s_q,     acc_s_d;
    logic [WIDTH_O-1:0] acc_c_q,     acc_c_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic               ovf_q,       ovf_d;
    logic [WIDTH_O-1:0] result_q,    result_d;
    logic [CNT_W-1:0]   count_out_q, count_out_d;
    logic               ovf_out_q,   ovf_out_d;

    // Inputs zero-extended to accumulator width.
    logic [WIDTH_O-1:0] ext_sum;
    logic [WIDTH_O-1:0] ext_carry;
    assign ext_sum   = {{(WIDTH_O-WIDTH_I){1'b0}}, cs_sum_i};
    assign ext_carry = {{(WIDTH_O-WIDTH_I){1'b0}}, cs_carry_i};

    // Two cascaded 3:2 levels. Carry vectors are produced already shifted
    // left by one; the carry out of the top bit is dropped (modulo 2^WIDTH_O).
    logic [WIDTH_O-1:0] l1_s, l1_c;
    logic [WIDTH_O-1:0] l2_s, l2_c;

    generate
        for (genvar gi = 0; gi < WIDTH_O; gi++) begin : g_csa
            assign l1_s[gi] = acc_s_q[gi] ^ acc_c_q[gi] ^ ext_sum[gi];
            assign l2_s[gi] = l1_s[gi] ^ l1_c[gi] ^ ext_carry[gi];
            if (gi == 0) begin : g_lsb
                assign l1_c[gi] = 1'b0;
                assign l2_c[gi] = 1'b0;
            end else begin : g_upper
                assign l1_c[gi] = (acc_s_q[gi-1] & acc_c_q[gi-1])
                                | (acc_s_q[gi-1] & ext_sum[gi-1])
                                | (acc_c_q[gi-1] & ext_sum[gi-1]);
                assign l2_c[gi] = (l1_s[gi-1] & l1_c[gi-1])
                                | (l1_s[gi-1] & ext_carry[gi-1])
                                | (l1_c[gi-1] & ext_carry[gi-1]);
            end
        end
    endgenerate

    // Next-state logic for the accumulate / resolve / present sequence.
    always_comb begin
        state_d     = state_q;
        acc_s_d     = acc_s_q;
        acc_c_d     = acc_c_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        count_out_d = count_out_q;
        ovf_out_d   = ovf_out_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid_i) begin
                    acc_s_d = l2_s;
                    acc_c_d = l2_c;
                    if (count_q == CNT_W'(MAX_TERMS)) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (in_last_i) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                result_d    = acc_s_q + acc_c_q;
                count_out_d = count_q;
                ovf_out_d   = ovf_q;
                state_d     = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_ready_i) begin
                    acc_s_d = '0;
                    acc_c_d = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_ACCUM;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            count_out_q <= '0;
            ovf_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_s_q     <= acc_s_d;
            acc_c_q     <= acc_c_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            count_out_q <= count_out_d;
            ovf_out_q   <= ovf_out_d;
        end
    end

    assign in_ready_o  = (state_q == ST_ACCUM);
    assign out_valid_o = (state_q == ST_OUTPUT);
    assign result_o    = result_q;
    assign count_o     = count_out_q;
    assign overflow_o  = ovf_out_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench for csa_accumulator: a packet-level arithmetic model
// compared every cycle, plus directed packets with hand-computed results.
module tb_csa_accumulator;

    localparam int WIDTH_I = 8;
    localparam int WIDTH_O = 13;
    localparam int CNT_W   = 5;
    localparam int MODW    = 8192;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH_I-1:0] cs_sum = '0;
    logic [WIDTH_I-1:0] cs_carry = '0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [WIDTH_O-1:0] result;
    logic [CNT_W-1:0]   count;
    logic               overflow;

    int checks = 0;
    int errors = 0;

    csa_accumulator dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .cs_sum_i    (cs_sum),
        .cs_carry_i  (cs_carry),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .count_o     (count),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: running integer sum of beats, beat count and a
    // busy phase (0 accepting, 1 resolving, 2 presenting a result).
    int m_phase = 0;
    int m_sum = 0, m_cnt = 0;
    bit m_ovf = 0;
    int m_res = 0, m_rcnt = 0;
    bit m_rovf = 0;
    bit model_live = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0; m_sum <= 0; m_cnt <= 0; m_ovf <= 0;
            m_res <= 0; m_rcnt <= 0; m_rovf <= 0; model_live <= 1;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_sum <= (m_sum + int'(cs_sum) + int'(cs_carry)) % MODW;
                    if (m_cnt == 16) m_ovf <= 1; else m_cnt <= m_cnt + 1;
                    if (in_last) m_phase <= 1;
                end
                1: begin
                    m_res <= m_sum; m_rcnt <= m_cnt; m_rovf <= m_ovf; m_phase <= 2;
                end
                default: if (out_ready) begin
                    m_sum <= 0; m_cnt <= 0; m_ovf <= 0; m_phase <= 0;
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (model_live && !rst) begin
            chk("model_in_ready", int'(in_ready), int'(m_phase == 0));
            chk("model_out_valid", int'(out_valid), int'(m_phase == 2));
            chk("model_result", int'(result), m_res);
            chk("model_count", int'(count), m_rcnt);
            chk("model_overflow", int'(overflow), int'(m_rovf));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input int s, input int c, input bit last, input int gap);
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            cs_sum   = 8'($urandom);
            cs_carry = 8'($urandom);
            in_last  = 1'b1;
            step();
        end
        in_valid = 1'b1;
        cs_sum   = 8'(s);
        cs_carry = 8'(c);
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string name, input int exp_res, input int exp_cnt, input bit exp_ovf);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_result"}, int'(result), exp_res);
        chk({name, "_count"}, int'(count), exp_cnt);
        chk({name, "_overflow"}, int'(overflow), int'(exp_ovf));
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_ready_after_hs"}, int'(in_ready), 1);
        chk({name, "_valid_after_hs"}, int'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        step(); step();
        rst = 1'b0;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_count", int'(count), 0);
        step();

        // Single beat, latency: resolve cycle then valid.
        send_beat(8'h0F, 8'h01, 1'b1, 0);
        chk("single_latency_resolve", int'(out_valid), 0);
        chk("single_latency_ready", int'(in_ready), 0);
        step();
        chk("single_latency_valid", int'(out_valid), 1);
        wait_out("single", 'h010, 1, 1'b0);
        handshake("single");

        // Four beats with gaps; out_ready held high early must do nothing.
        out_ready = 1'b1;
        send_beat(8'hFF, 8'hFF, 1'b0, 0);
        send_beat(8'hFF, 8'hFF, 1'b0, 1);
        send_beat(8'hFF, 8'hFF, 1'b0, 2);
        out_ready = 1'b0;
        send_beat(8'hFF, 8'hFF, 1'b1, 3);
        wait_out("four", 'h7F8, 4, 1'b0);

        // Backpressure: five stalled cycles, everything held.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_result", int'(result), 'h7F8);
            chk("stall_count", int'(count), 4);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        handshake("four");
        send_beat(1, 0, 1'b1, 0);
        wait_out("after_clear", 'h001, 1, 1'b0);
        handshake("after_clear");

        // Seventeen beats: overflow, wrapped sum, saturated count.
        for (int i = 0; i < 17; i++) send_beat(8'hFF, 8'hFF, (i == 16), 0);
        wait_out("ovf17", 'h1DE, 16, 1'b1);
        handshake("ovf17");
        send_beat(2, 3, 1'b1, 1);
        wait_out("post_ovf", 5, 1, 1'b0);
        handshake("post_ovf");

        // Reset mid-packet discards partial state.
        send_beat(8'h10, 8'h10, 1'b0, 0);
        send_beat(8'h10, 8'h10, 1'b0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_count", int'(count), 0);
        chk("midrst_overflow", int'(overflow), 0);
        send_beat(3, 4, 1'b1, 0);
        wait_out("midrst_pkt", 7, 1, 1'b0);
        handshake("midrst_pkt");

        // Sixteen beats: largest sum without wrap, no overflow.
        for (int i = 0; i < 16; i++) send_beat(8'hFF, 8'hFF, (i == 15), (i % 2));
        wait_out("max16", 'h1FE0, 16, 1'b0);
        handshake("max16");

        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
